text_buffer_ctrl: RTL and testbench

//   Owns the 7x20 character buffer that the pixel encoder reads via (rin,cin)->charout.

---
 rtl/text_buffer_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_text_buffer_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl
//   Owns the ROWS x COLS character buffer read by the pixel encoder and sequences every
//   write into it from a byte stream (keyboard/UART) arriving over valid/ready.
//   Handles the cursor, newline (0x0A/0x0D), backspace (0x08), clear-screen (0x0C),
//   line wrap and end-of-screen. The display read port is asynchronous and is never
//   stalled by writes; partially cleared screens are visible while a sequence runs.
//
//   Optional feature: define SCROLL_EN to scroll the screen up at end-of-screen instead
//   of wrapping the cursor back to row 0.
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous active-high reset (aborts any sequence, starts a clear)
//   in_valid   in   in_char is valid
//   in_char    in   input byte
//   in_ready   out  a byte can be accepted this cycle (only when idle)
//   rd_row     in   display read row
//   rd_col     in   display read column
//   rd_char    out  character at (rd_row, rd_col); BLANK when out of range
//   cursor_row out  current cursor row
//   cursor_col out  current cursor column
//   busy       out  multi-cycle sequence in progress (~in_ready)
module text_buffer_ctrl #(
    parameter int unsigned ROWS      = 7,
    parameter int unsigned COLS      = 20,
    parameter logic [7:0]  BLANK     = 8'h20,
    parameter logic [7:0]  MAX_GLYPH = 8'h81
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_char,
    output logic       in_ready,
    input  logic [3:0] rd_row,
    input  logic [5:0] rd_col,
    output logic [7:0] rd_char,
    output logic [3:0] cursor_row,
    output logic [5:0] cursor_col,
    output logic       busy
);

    localparam int unsigned CELLS    = ROWS * COLS;
    localparam logic [3:0]  LAST_ROW = 4'(ROWS - 1);
    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);

`ifdef SCROLL_EN
    localparam logic [3:0]  LAST_SRC = 4'(ROWS - 2);
    typedef enum logic [1:0] {StIdle, StClear, StLineClr, StScroll} state_e;
`else
    typedef enum logic [1:0] {StIdle, StClear, StLineClr} state_e;
`endif

    state_e     state_q, state_d;
    logic [3:0] cur_row_q, cur_row_d;
    logic [5:0] cur_col_q, cur_col_d;
    logic [3:0] seq_row_q, seq_row_d;
    logic [5:0] seq_col_q, seq_col_d;
    logic       in_ready_q;

    logic [7:0] ram [CELLS];
    logic       ram_we;
    logic [7:0] ram_waddr;
    logic [7:0] ram_wdata;

    logic       accept;
    logic       printable;
    logic       do_advance;

    function automatic logic [7:0] addr_of(input logic [3:0] r, input logic [5:0] c);
        return 8'(r) * 8'(COLS) + 8'(c);
    endfunction

    assign accept    = in_valid & in_ready_q;
    assign printable = (in_char >= 8'h20) && (in_char <= MAX_GLYPH) && (in_char != 8'h7F);

    always_comb begin
        state_d    = state_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        seq_row_d  = seq_row_q;
        seq_col_d  = seq_col_q;
        ram_we     = 1'b0;
        ram_waddr  = addr_of(cur_row_q, cur_col_q);
        ram_wdata  = BLANK;
        do_advance = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (printable) begin
                        ram_we    = 1'b1;
                        ram_wdata = in_char;
                        if (cur_col_q == LAST_COL) begin
                            do_advance = 1'b1;
                        end else begin
                            cur_col_d = cur_col_q + 6'd1;
                        end
                    end else if (in_char == 8'h0A || in_char == 8'h0D) begin
                        do_advance = 1'b1;
                    end else if (in_char == 8'h08) begin
                        if (cur_col_q != 6'd0) begin
                            cur_col_d = cur_col_q - 6'd1;
                            ram_we    = 1'b1;
                            ram_waddr = addr_of(cur_row_q, cur_col_q - 6'd1);
                        end else if (cur_row_q != 4'd0) begin
                            cur_row_d = cur_row_q - 4'd1;
                            cur_col_d = LAST_COL;
                            ram_we    = 1'b1;
                            ram_waddr = addr_of(cur_row_q - 4'd1, LAST_COL);
                        end
                    end else if (in_char == 8'h0C) begin
                        cur_row_d = 4'd0;
                        cur_col_d = 6'd0;
                        seq_row_d = 4'd0;
                        seq_col_d = 6'd0;
                        state_d   = StClear;
                    end
                end
            end
            StClear: begin
                ram_we    = 1'b1;
                ram_waddr = addr_of(seq_row_q, seq_col_q);
                if (seq_col_q == LAST_COL) begin
                    seq_col_d = 6'd0;
                    if (seq_row_q == LAST_ROW) begin
                        state_d = StIdle;
                    end else begin
                        seq_row_d = seq_row_q + 4'd1;
                    end
                end else begin
                    seq_col_d = seq_col_q + 6'd1;
                end
            end
            StLineClr: begin
                ram_we    = 1'b1;
                ram_waddr = addr_of(seq_row_q, seq_col_q);
                if (seq_col_q == LAST_COL) begin
                    state_d = StIdle;
                end else begin
                    seq_col_d = seq_col_q + 6'd1;
                end
            end
`ifdef SCROLL_EN
            StScroll: begin
                // Copy the cell one row below into the current cell.
                ram_we    = 1'b1;
                ram_waddr = addr_of(seq_row_q, seq_col_q);
                ram_wdata = ram[addr_of(seq_row_q + 4'd1, seq_col_q)];
                if (seq_col_q == LAST_COL) begin
                    seq_col_d = 6'd0;
                    if (seq_row_q == LAST_SRC) begin
                        seq_row_d = LAST_ROW;
                        state_d   = StLineClr;
                    end else begin
                        seq_row_d = seq_row_q + 4'd1;
                    end
                end else begin
                    seq_col_d = seq_col_q + 6'd1;
                end
            end
`endif
            default: begin
                state_d = StClear;
            end
        endcase

        // Newline / wrap: cursor moves to column 0 of the next line, which is cleared.
        if (do_advance) begin
            cur_col_d = 6'd0;
            seq_col_d = 6'd0;
            if (cur_row_q != LAST_ROW) begin
                cur_row_d = cur_row_q + 4'd1;
                seq_row_d = cur_row_q + 4'd1;
                state_d   = StLineClr;
            end else begin
`ifdef SCROLL_EN
                seq_row_d = 4'd0;
                state_d   = StScroll;
`else
                cur_row_d = 4'd0;
                seq_row_d = 4'd0;
                state_d   = StLineClr;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            cur_row_q  <= 4'd0;
            cur_col_q  <= 6'd0;
            seq_row_q  <= 4'd0;
            seq_col_q  <= 6'd0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            seq_row_q  <= seq_row_d;
            seq_col_q  <= seq_col_d;
            in_ready_q <= (state_d == StIdle);
        end
    end

    // Storage is not reset; the clear sequence started by reset initialises it.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    always_comb begin
        rd_char = BLANK;
        if (rd_row < 4'(ROWS) && rd_col < 6'(COLS)) begin
            rd_char = ram[addr_of(rd_row, rd_col)];
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = ~in_ready_q;
    assign cursor_row = cur_row_q;
    assign cursor_col = cur_col_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
module tb_text_buffer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic       in_ready;
    logic [3:0] rd_row = 4'd0;
    logic [5:0] rd_col = 6'd0;
    logic [7:0] rd_char;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;
    logic       busy;

    text_buffer_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_char    (rd_char),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // kind: 0 = cell contents, 1 = cursor position, 2 = in_ready level
    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] r;
        logic [5:0] c;
        logic [9:0] exp;
    } chk_t;

    chk_t chk_q[$];
    int   busy_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic mon_en = 1'b0;
    int   cr;

    // ---------------- scoreboard pushes ----------------
    task automatic push_cell(input int r, input int c, input logic [7:0] e);
        chk_t k;
        k.kind = 2'd0; k.r = 4'(r); k.c = 6'(c); k.exp = {2'b00, e};
        chk_q.push_back(k);
    endtask

    task automatic push_row(input int r, input logic [7:0] e);
        for (int c = 0; c < 20; c++) push_cell(r, c, e);
    endtask

    task automatic push_screen(input logic [7:0] e);
        for (int r = 0; r < 7; r++) push_row(r, e);
    endtask

    task automatic push_cursor(input int r, input int c);
        chk_t k;
        k.kind = 2'd1; k.r = 4'd0; k.c = 6'd0; k.exp = {4'(r), 6'(c)};
        chk_q.push_back(k);
    endtask

    task automatic push_ready(input logic e);
        chk_t k;
        k.kind = 2'd2; k.r = 4'd0; k.c = 6'd0; k.exp = {9'd0, e};
        chk_q.push_back(k);
    endtask

    // ---------------- stimulus helpers (all end at posedge + 1) ----------------
    task automatic send(input logic [7:0] ch);
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_vec++; n_miss++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
        end else begin
            in_valid = 1'b1;
            in_char  = ch;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            n_vec++; n_miss++;
            $display("FAIL idle_timeout: in_ready=%0b after %0d cycles, want 1", in_ready, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (chk_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        if (chk_q.size() != 0) begin
            n_vec++; n_miss++;
            $display("FAIL drain_timeout: %0d checks pending, want 0", chk_q.size());
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        chk_t k;
        int   run;
        int   e;
        run = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_vec++;
                if (busy !== ~in_ready) begin
                    n_miss++;
                    $display("FAIL busy_level: busy=%0b in_ready=%0b, want busy=~in_ready",
                             busy, in_ready);
                end
                if (reset) begin
                    run = 0;
                end else if (!in_ready) begin
                    run++;
                end else if (run > 0) begin
                    n_vec++;
                    if (busy_q.size() == 0) begin
                        n_miss++;
                        $display("FAIL busy_unexpected: busy for %0d cycles, want none", run);
                    end else begin
                        e = busy_q.pop_front();
                        if (run != e) begin
                            n_miss++;
                            $display("FAIL busy_len: busy for %0d cycles, want %0d", run, e);
                        end
                    end
                    run = 0;
                end
                if (chk_q.size() != 0) begin
                    k = chk_q.pop_front();
                    n_vec++;
                    unique case (k.kind)
                        2'd0: begin
                            rd_row = k.r;
                            rd_col = k.c;
                            #1;
                            if (rd_char !== k.exp[7:0]) begin
                                n_miss++;
                                $display("FAIL cell(%0d,%0d): got %h want %h",
                                         k.r, k.c, rd_char, k.exp[7:0]);
                            end
                        end
                        2'd1: begin
                            if ({cursor_row, cursor_col} !== k.exp) begin
                                n_miss++;
                                $display("FAIL cursor: got (%0d,%0d) want (%0d,%0d)",
                                         cursor_row, cursor_col, k.exp[9:6], k.exp[5:0]);
                            end
                        end
                        default: begin
                            if (in_ready !== k.exp[0]) begin
                                n_miss++;
                                $display("FAIL ready: got %0b want %0b", in_ready, k.exp[0]);
                            end
                        end
                    endcase
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        // 1: reset, full-screen clear
        busy_q.push_back(140);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        wait_idle();
        push_screen(8'h20);
        push_cell(7, 0, 8'h20);
        push_cell(0, 20, 8'h20);
        push_cursor(0, 0);
        push_ready(1'b1);
        drain();

        // 2: 20 printable bytes back-to-back wrap into row 1
        busy_q.push_back(20);
        for (int i = 0; i < 20; i++) send(8'h41);
        wait_idle();
        push_row(0, 8'h41);
        push_cell(1, 0, 8'h20);
        push_cursor(1, 0);
        drain();

        // 3: backspace across a line boundary, within a line, and at home
        send(8'h08);
        push_cursor(0, 19);
        push_cell(0, 19, 8'h20);
        push_cell(0, 18, 8'h41);
        drain();
        for (int i = 0; i < 19; i++) send(8'h08);
        send(8'h58);
        send(8'h59);
        send(8'h08);
        push_cursor(0, 1);
        push_cell(0, 0, 8'h58);
        push_cell(0, 1, 8'h20);
        drain();
        send(8'h08);
        send(8'h08);
        push_cursor(0, 0);
        push_cell(0, 0, 8'h20);
        push_ready(1'b1);
        drain();

        // 4: newlines down to the last row, then end-of-screen
        send(8'h5A);
        for (int i = 0; i < 6; i++) begin
            busy_q.push_back(20);
            send((i == 2) ? 8'h0D : 8'h0A);
        end
        wait_idle();
        push_cursor(6, 0);
        drain();
        send(8'h42);
`ifdef SCROLL_EN
        busy_q.push_back(140);
`else
        busy_q.push_back(20);
`endif
        send(8'h0A);
        wait_idle();
        push_row(0, 8'h20);
`ifdef SCROLL_EN
        cr = 6;
        push_cursor(6, 0);
        push_cell(5, 0, 8'h42);
        push_row(6, 8'h20);
`else
        cr = 0;
        push_cursor(0, 0);
        push_cell(6, 0, 8'h42);
        push_cell(5, 0, 8'h20);
`endif
        drain();

        // 5: non-glyph codes are ignored; MAX_GLYPH prints; form feed clears
        send(8'h48);
        send(8'h49);
        send(8'h07);
        send(8'h7F);
        send(8'h82);
        send(8'h1F);
        push_cursor(cr, 2);
        push_cell(cr, 0, 8'h48);
        push_cell(cr, 1, 8'h49);
        push_cell(cr, 2, 8'h20);
        push_ready(1'b1);
        drain();
        send(8'h81);
        push_cursor(cr, 3);
        push_cell(cr, 2, 8'h81);
        push_cell(cr, 3, 8'h20);
        drain();
        busy_q.push_back(140);
        send(8'h0C);
        wait_idle();
        push_screen(8'h20);
        push_cursor(0, 0);
        drain();

        // 6: reset in the middle of a line clear restarts a full clear
        send(8'h51);
        send(8'h0A);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        busy_q.push_back(140);
        pulse_reset();
        push_cursor(0, 0);
        push_ready(1'b0);
        wait_idle();
        push_screen(8'h20);
        drain();
        send(8'h41);
        push_cell(0, 0, 8'h41);
        push_cursor(0, 1);
        drain();

        repeat (3) @(posedge clk);
        n_vec++;
        if (busy_q.size() != 0) begin
            n_miss++;
            $display("FAIL busy_pending: %0d busy periods never seen, want 0", busy_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
